// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared types and sizes for the 8:1 mux scan sequencer
package mux_scan_pkg;
  localparam int N_CH  = 8;
  localparam int SEL_W = 3;
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
endpackage

// File: rtl/mux_settle_timer.sv
// mux_settle_timer: loadable down-counter that flags when the settle time has elapsed
module mux_settle_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] r_cnt;
  // load takes priority; otherwise count down and park at zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (load) r_cnt <= load_val;
    else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  assign zero = r_cnt == '0;
endmodule

// File: rtl/mux8_scan_ctrl.sv
// mux8_scan_ctrl: steps an 8:1 mux through all channels, samples each, hands the word off on valid/ready
module mux8_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [SEL_W-1:0] mux_sel,
  input  logic             mux_y,
  output logic             busy,
  output logic [N_CH-1:0]  data,
  output logic             valid,
  input  logic             ready
);
  state_t           r_state, w_next;
  logic [SEL_W-1:0] r_sel;
  logic [N_CH-1:0]  r_shadow, r_data, w_word;
  logic             r_valid, w_zero, w_start_scan, w_sample, w_last, w_load;

  assign w_last = r_sel == SEL_W'(N_CH - 1);
  assign w_load = w_start_scan | (w_sample & ~w_last);

  mux_settle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .load_val (CNT_W'(SETTLE_CYCLES)),
    .zero     (w_zero)
  );

  // shadow word with the current channel's sample merged in
  always_comb begin
    w_word        = r_shadow;
    w_word[r_sel] = mux_y;
  end

  // next state plus scan-start and sample strobes
  always_comb begin
    w_next       = r_state;
    w_start_scan = 1'b0;
    w_sample     = 1'b0;
    case (r_state)
      IDLE: if (start) begin
        w_next       = SETTLE;
        w_start_scan = 1'b1;
      end
      SETTLE: if (w_zero) begin
        w_sample = 1'b1;
        if (w_last) w_next = HOLD;
      end
      HOLD: if (ready) begin
        w_next       = start ? SETTLE : IDLE;
        w_start_scan = start;
      end
      default: w_next = IDLE;
    endcase
  end

  // state, select, shadow and output word registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state  <= IDLE;
      r_sel    <= '0;
      r_shadow <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == HOLD && ready) r_valid <= 1'b0;
      if (w_start_scan) begin
        r_sel    <= '0;
        r_shadow <= '0;
      end else if (w_sample) begin
        r_shadow <= w_word;
        r_sel    <= w_last ? '0 : r_sel + 1'b1;
        if (w_last) begin
          r_data  <= w_word;
          r_valid <= 1'b1;
        end
      end
    end

  assign mux_sel = r_sel;
  assign busy    = r_state == SETTLE;
  assign data    = r_data;
  assign valid   = r_valid;
endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// tb_mux8_scan_ctrl: directed checks of the scan sequencer at SETTLE_CYCLES=1 and SETTLE_CYCLES=0
module tb_mux8_scan_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       start = 1'b0, ready = 1'b0, start0 = 1'b0, ready0 = 1'b0;
  logic [7:0] in_vec = 8'h00, in_vec0 = 8'h00;
  logic [2:0] mux_sel, mux_sel0;
  logic       mux_y, mux_y0, busy, busy0, valid, valid0;
  logic [7:0] data, data0;
  logic [12:0] obs, obs0, exp_v;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  // three-level mux2 tree model
  function automatic logic tree(input logic [7:0] v, input logic [2:0] s);
    logic [3:0] l1;
    logic [1:0] l2;
    for (int i = 0; i < 4; i++) l1[i] = s[0] ? v[2*i+1] : v[2*i];
    for (int i = 0; i < 2; i++) l2[i] = s[1] ? l1[2*i+1] : l1[2*i];
    return s[2] ? l2[1] : l2[0];
  endfunction

  assign mux_y  = tree(in_vec, mux_sel);
  assign mux_y0 = tree(in_vec0, mux_sel0);
  assign obs    = {busy, valid, mux_sel, data};
  assign obs0   = {busy0, valid0, mux_sel0, data0};

  mux8_scan_ctrl #(.SETTLE_CYCLES(1), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mux_sel(mux_sel), .mux_y(mux_y),
    .busy(busy), .data(data), .valid(valid), .ready(ready)
  );

  mux8_scan_ctrl #(.SETTLE_CYCLES(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .mux_sel(mux_sel0), .mux_y(mux_y0),
    .busy(busy0), .data(data0), .valid(valid0), .ready(ready0)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) tick;
    checks++;
    if (obs !== 13'h0) begin errors++; $display("FAIL reset obs=%h exp=%h", obs, 13'h0); end
    checks++;
    if (obs0 !== 13'h0) begin errors++; $display("FAIL reset0 obs=%h exp=%h", obs0, 13'h0); end
    @(negedge clk) rst_n = 1'b1;
    tick;
  endtask

  task automatic test_scan;
    in_vec = 8'b1010_0110;
    start = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if (obs !== {1'b1, 1'b0, 3'd0, 8'h00}) begin errors++; $display("FAIL scan_t0 obs=%h", obs); end
    for (int m = 1; m <= 16; m++) begin
      tick;
      exp_v = (m < 16) ? {1'b1, 1'b0, 3'(m / 2), 8'h00} : {1'b0, 1'b1, 3'd0, 8'hA6};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL scan m=%0d obs=%h exp=%h", m, obs, exp_v); end
    end
  endtask

  task automatic test_hold;
    for (int m = 0; m < 5; m++) begin
      tick;
      checks++;
      if (obs !== {1'b0, 1'b1, 3'd0, 8'hA6}) begin errors++; $display("FAIL hold m=%0d obs=%h", m, obs); end
    end
    ready = 1'b1;
    tick;
    ready = 1'b0;
    checks++;
    if (obs !== {1'b0, 1'b0, 3'd0, 8'hA6}) begin errors++; $display("FAIL hold_ack obs=%h", obs); end
    tick;
    checks++;
    if (obs !== {1'b0, 1'b0, 3'd0, 8'hA6}) begin errors++; $display("FAIL hold_idle obs=%h", obs); end
  endtask

  task automatic test_back_to_back;
    in_vec = 8'hA6;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (16) tick;
    checks++;
    if (obs !== {1'b0, 1'b1, 3'd0, 8'hA6}) begin errors++; $display("FAIL b2b_first obs=%h", obs); end
    in_vec = 8'h3C;
    ready = 1'b1;
    start = 1'b1;
    tick;
    ready = 1'b0;
    start = 1'b0;
    checks++;
    if (obs !== {1'b1, 1'b0, 3'd0, 8'hA6}) begin errors++; $display("FAIL b2b_restart obs=%h", obs); end
    for (int m = 1; m <= 16; m++) begin
      tick;
      exp_v = (m < 16) ? {1'b1, 1'b0, 3'(m / 2), 8'hA6} : {1'b0, 1'b1, 3'd0, 8'h3C};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL b2b m=%0d obs=%h exp=%h", m, obs, exp_v); end
    end
    ready = 1'b1;
    tick;
    ready = 1'b0;
    checks++;
    if (obs !== {1'b0, 1'b0, 3'd0, 8'h3C}) begin errors++; $display("FAIL b2b_drain obs=%h", obs); end
  endtask

  task automatic test_start_ignored;
    in_vec = 8'h5A;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int m = 1; m <= 16; m++) begin
      tick;
      start = (m % 4 == 1) && (m < 15);
      exp_v = (m < 16) ? {1'b1, 1'b0, 3'(m / 2), 8'h3C} : {1'b0, 1'b1, 3'd0, 8'h5A};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL ign m=%0d obs=%h exp=%h", m, obs, exp_v); end
    end
    start = 1'b0;
    ready = 1'b1;
    tick;
    ready = 1'b0;
    checks++;
    if (obs !== {1'b0, 1'b0, 3'd0, 8'h5A}) begin errors++; $display("FAIL ign_drain obs=%h", obs); end
  endtask

  task automatic test_reset_midscan;
    in_vec = 8'hC3;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (8) tick;
    checks++;
    if (obs !== {1'b1, 1'b0, 3'd4, 8'h5A}) begin errors++; $display("FAIL mid_sel4 obs=%h", obs); end
    rst_n = 1'b0;
    #2;
    checks++;
    if (obs !== 13'h0) begin errors++; $display("FAIL mid_async obs=%h exp=%h", obs, 13'h0); end
    tick;
    @(negedge clk) rst_n = 1'b1;
    in_vec = 8'hFF;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int m = 1; m <= 16; m++) begin
      tick;
      exp_v = (m < 16) ? {1'b1, 1'b0, 3'(m / 2), 8'h00} : {1'b0, 1'b1, 3'd0, 8'hFF};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL post_rst m=%0d obs=%h exp=%h", m, obs, exp_v); end
    end
    ready = 1'b1;
    tick;
    ready = 1'b0;
  endtask

  task automatic test_settle0;
    in_vec0 = 8'h01;
    start0 = 1'b1;
    tick;
    start0 = 1'b0;
    checks++;
    if (obs0 !== {1'b1, 1'b0, 3'd0, 8'h00}) begin errors++; $display("FAIL s0_t0 obs=%h", obs0); end
    for (int m = 1; m <= 8; m++) begin
      tick;
      exp_v = (m < 8) ? {1'b1, 1'b0, 3'(m), 8'h00} : {1'b0, 1'b1, 3'd0, 8'h01};
      checks++;
      if (obs0 !== exp_v) begin errors++; $display("FAIL s0 m=%0d obs=%h exp=%h", m, obs0, exp_v); end
    end
  endtask

  initial begin
    test_reset;
    test_scan;
    test_hold;
    test_back_to_back;
    test_start_ignored;
    test_reset_midscan;
    test_settle0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux8_scan_ctrl.md
Name: mux8_scan_ctrl

Overview:
- Upstream sequencer for the 8:1 mux tree (three-level mux2 tree, select s[2:0], output y).
- On a start pulse, drives the mux select through channels 0..7 and waits a programmable settle time per channel.
- Samples the mux output each channel and assembles an 8-bit word, bit k = channel k.
- Delivers the word downstream on a valid/ready handshake.

Parameters:
- SETTLE_CYCLES, 1, idle clocks after each select change before sampling (legal range 0..15).
- CNT_W, 4, width of the settle counter; must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  scan request; sampled only in IDLE.
- mux_sel  out  3  drives the mux tree select s[2:0].
- mux_y  in  1  mux tree output y; synchronous to clk, combinational from mux_sel.
- busy  out  1  high while a scan is in progress (SETTLE state).
- data  out  8  last completed scan word; bit k = channel k.
- valid  out  1  data holds an unconsumed word.
- ready  in  1  downstream accepts data when valid && ready.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous, active-low. While rst_n=0, all outputs are 0 and the state is IDLE: mux_sel=0, busy=0, data=8'h00, valid=0, shadow register=0, counter=0.
- FSM states:
  - IDLE: mux_sel=0, busy=0, valid=0. start=1 at edge T0 → SETTLE, mux_sel=0, cnt=SETTLE_CYCLES, shadow cleared.
  - SETTLE: busy=1. On each edge with cnt≠0, decrement cnt. On an edge with cnt=0:
    - shadow[mux_sel] <= mux_y.
    - If mux_sel<7: mux_sel increments and cnt reloads SETTLE_CYCLES.
    - If mux_sel=7: data <= shadow with bit 7 = mux_y, valid <= 1, mux_sel <= 0 → HOLD.
  - HOLD: busy=0, valid=1, data stable. On an edge with ready=1: valid <= 0.
    - If start=1 on that same edge: go directly to SETTLE (back-to-back scan, same setup as from IDLE).
    - Otherwise: → IDLE.
- Timing: channel k is sampled at edge T0+(k+1)(SETTLE_CYCLES+1). valid rises at edge T0+8(SETTLE_CYCLES+1), which is 16 clocks for the default setting.
- SETTLE_CYCLES=0 gives 1 clock per channel and 8 clocks per scan.
- start is ignored in SETTLE. In HOLD, start is honoured only together with ready. A level-held start in IDLE causes continuous scans.
- data changes only at scan completion; during a scan it keeps the previous word.
- ready is ignored when valid=0.
- Reset asserted mid-scan or in HOLD: the partial or pending word is discarded and all outputs return to reset values immediately (asynchronous).
- Reset deassertion is synchronised externally. The first edge after release may accept start.
- mux_sel wraps only via the explicit return to 0, never by arithmetic overflow.

Decomposition:
- Shared package mux_scan_pkg:
  - state enum {IDLE, SETTLE, HOLD}, 2 bits.
  - constants N_CH=8, SEL_W=3.
- Optional sub-module mux_settle_timer: loadable down-counter (ports load, load_val, zero) that holds the settle count. All other logic stays in mux8_scan_ctrl.

Test Plan:
- Reset, then start pulse with mux_y driven from a model of the 8:1 tree over inputs {h..a}=8'b1010_0110, SETTLE_CYCLES=1 → mux_sel steps 0..7 every 2 clocks; valid at T0+16; data=8'hA6; busy low at the same edge.
- Hold ready=0 for 5 clocks after valid → data=8'hA6 and valid=1 stable throughout. ready=1 → valid=0 on the next edge; state IDLE, mux_sel=0.
- In HOLD, assert ready=1 and start=1 on the same edge with new inputs 8'h3C → no IDLE cycle; busy=1 on the next clock; second word 8'h3C valid 16 clocks later.
- Pulse start repeatedly during SETTLE → no restart; single word produced at T0+16.
- Assert rst_n=0 while mux_sel=4 → outputs immediately 0. After release, a new start with inputs 8'hFF yields data=8'hFF, with no residue from the aborted scan.
- Build with SETTLE_CYCLES=0, inputs 8'h01 → mux_sel changes every clock; data=8'h01; valid at T0+8.
